// File: rtl/ysyx_22040125_mdu_pkg.sv
// Shared constants and types for the iterative multiply/divide unit.
package ysyx_22040125_mdu_pkg;

   localparam int unsigned XLEN_DEFAULT = 64;

   localparam int unsigned OP_MUL    = 0;
   localparam int unsigned OP_MULH   = 1;
   localparam int unsigned OP_MULHSU = 2;
   localparam int unsigned OP_MULHU  = 3;
   localparam int unsigned OP_DIV    = 4;
   localparam int unsigned OP_DIVU   = 5;
   localparam int unsigned OP_REM    = 6;
   localparam int unsigned OP_REMU   = 7;

   typedef enum logic [1:0] {IDLE, CALC, DONE} mdu_state_e;

   function automatic logic is_onehot8(input logic [7:0] v);
      return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
   endfunction

endpackage

// File: rtl/ysyx_22040125_mdu_if.sv
// EXU <-> MDU request/response bundle; master is the EXU, slave is the MDU.
interface ysyx_22040125_mdu_if
   import ysyx_22040125_mdu_pkg::*;
#(
   parameter int unsigned XLEN = XLEN_DEFAULT
);
   logic            in_valid;
   logic            in_ready;
   logic [7:0]      op;
   logic            is_word;
   logic [XLEN-1:0] src1;
   logic [XLEN-1:0] src2;
   logic            flush;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] data_rd;
   logic            busy;

   modport master (
      output in_valid, op, is_word, src1, src2, flush, out_ready,
      input  in_ready, out_valid, data_rd, busy
   );

   modport slave (
      input  in_valid, op, is_word, src1, src2, flush, out_ready,
      output in_ready, out_valid, data_rd, busy
   );
endinterface

// File: rtl/ysyx_22040125_mdu_divcore.sv
// Restoring divider on unsigned magnitudes, one quotient bit per cycle.
// The dividend arrives MSB-aligned so an n_i-bit divide needs exactly n_i steps.
module ysyx_22040125_mdu_divcore
   import ysyx_22040125_mdu_pkg::*;
#(
   parameter int unsigned XLEN = XLEN_DEFAULT,
   parameter int unsigned CW   = $clog2(XLEN) + 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start_i,
   input  logic [CW-1:0]   n_i,
   input  logic [XLEN-1:0] dividend_i,
   input  logic [XLEN-1:0] divisor_i,
   output logic            done_o,
   output logic [XLEN-1:0] quotient_o,
   output logic [XLEN-1:0] remainder_o
);
   logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
   logic [CW-1:0]   cnt_q, cnt_d, n_q, n_d;
   logic [XLEN:0]   trial, diff;

   always_comb begin
      rem_d = rem_q;
      quo_d = quo_q;
      dvs_d = dvs_q;
      cnt_d = cnt_q;
      n_d   = n_q;
      // (XLEN+1)-bit partial remainder: shifted remainder plus next dividend bit
      trial = {rem_q, quo_q[XLEN-1]};
      diff  = trial - {1'b0, dvs_q};
      if (start_i) begin
         rem_d = '0;
         quo_d = dividend_i;
         dvs_d = divisor_i;
         cnt_d = '0;
         n_d   = n_i;
      end else if (cnt_q != n_q) begin
         cnt_d = cnt_q + 1'b1;
         quo_d = {quo_q[XLEN-2:0], ~diff[XLEN]};
         rem_d = diff[XLEN] ? trial[XLEN-1:0] : diff[XLEN-1:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem_q <= '0;
         quo_q <= '0;
         dvs_q <= '0;
         cnt_q <= '0;
         n_q   <= '0;
      end else begin
         rem_q <= rem_d;
         quo_q <= quo_d;
         dvs_q <= dvs_d;
         cnt_q <= cnt_d;
         n_q   <= n_d;
      end
   end

   assign done_o      = (cnt_q == n_q);
   assign quotient_o  = quo_q;
   assign remainder_o = rem_q;

endmodule

// File: rtl/ysyx_22040125_mdu.sv
// Multi-cycle RV64M multiply/divide unit with valid/ready handshakes.
// MDU_EARLY_OUT_EN: trivial divides and zero-operand multiplies finish in one cycle.
module ysyx_22040125_mdu
   import ysyx_22040125_mdu_pkg::*;
#(
   parameter int unsigned XLEN = XLEN_DEFAULT,
   parameter int unsigned WLEN = 32
) (
   input logic                clk,
   input logic                rst,
   ysyx_22040125_mdu_if.slave bus
);
   localparam int unsigned CW = $clog2(XLEN) + 1;

   mdu_state_e        state_q, state_d;
   logic              short_q, short_d, is_div_q, is_div_d, is_rem_q, is_rem_d;
   logic              is_hi_q, is_hi_d, word_q, word_d, neg_q, neg_d, rneg_q, rneg_d;
   logic              dz_q, dz_d;
   logic [CW-1:0]     cnt_q, cnt_d, n_q, n_d;
   logic [XLEN-1:0]   mcand_q, mcand_d, mplier_q, mplier_d, data_q, data_d;
   logic [2*XLEN-1:0] prod_q, prod_d, prod_s;

   logic              s1_sgn, s2_sgn, a_neg, b_neg, req_ok, req_div, req_rem, req_hi;
   logic              early_hit, div_start, div_done, fin;
   logic [XLEN-1:0]   a_ext, b_ext, a_mag, b_mag, early_res;
   logic [XLEN-1:0]   quo, rem, quo_s, rem_s, res;
   logic [CW-1:0]     n_req;

   function automatic logic [XLEN-1:0] ext_w(input logic [XLEN-1:0] v, input logic word,
                                             input logic sgn);
      if (!word) return v;
      return {{(XLEN-WLEN){sgn & v[WLEN-1]}}, v[WLEN-1:0]};
   endfunction

   always_comb begin
      s1_sgn  = bus.op[OP_MUL] | bus.op[OP_MULH] | bus.op[OP_MULHSU] | bus.op[OP_DIV] |
                bus.op[OP_REM];
      s2_sgn  = bus.op[OP_MUL] | bus.op[OP_MULH] | bus.op[OP_DIV] | bus.op[OP_REM];
      a_ext   = ext_w(bus.src1, bus.is_word, s1_sgn);
      b_ext   = ext_w(bus.src2, bus.is_word, s2_sgn);
      a_neg   = s1_sgn & a_ext[XLEN-1];
      b_neg   = s2_sgn & b_ext[XLEN-1];
      a_mag   = a_neg ? -a_ext : a_ext;
      b_mag   = b_neg ? -b_ext : b_ext;
      req_ok  = is_onehot8(bus.op);
      req_div = |bus.op[OP_REMU:OP_DIV];
      req_rem = bus.op[OP_REM] | bus.op[OP_REMU];
      req_hi  = |bus.op[OP_MULHU:OP_MULH];
      n_req   = bus.is_word ? CW'(WLEN) : CW'(XLEN);
   end

`ifdef MDU_EARLY_OUT_EN
   logic [XLEN-1:0] min_val;
   logic            ovf;
   always_comb begin
      min_val   = bus.is_word ? {{(XLEN-WLEN+1){1'b1}}, {(WLEN-1){1'b0}}}
                              : {1'b1, {(XLEN-1){1'b0}}};
      ovf       = s1_sgn && (a_ext == min_val) && (b_ext == '1);
      early_hit = 1'b0;
      early_res = '0;
      if (req_div) begin
         if (b_ext == '0) begin
            early_hit = 1'b1;
            early_res = req_rem ? a_ext : '1;
         end else if (ovf) begin
            early_hit = 1'b1;
            early_res = req_rem ? '0 : a_ext;
         end
      end else if ((a_ext == '0) || (b_ext == '0)) begin
         early_hit = 1'b1;
      end
   end
`else
   assign early_hit = 1'b0;
   assign early_res = '0;
`endif

   assign div_start = (state_q == IDLE) & bus.in_valid & ~bus.flush & req_ok & req_div &
                      ~early_hit;

   ysyx_22040125_mdu_divcore #(
      .XLEN (XLEN),
      .CW   (CW)
   ) u_divcore (
      .clk         (clk),
      .rst         (rst),
      .start_i     (div_start),
      .n_i         (n_req),
      .dividend_i  (bus.is_word ? (a_mag << (XLEN - WLEN)) : a_mag),
      .divisor_i   (b_mag),
      .done_o      (div_done),
      .quotient_o  (quo),
      .remainder_o (rem)
   );

   // Short requests (bad opcode or early-out) park their result in prod_q's low half.
   always_comb begin
      prod_s = neg_q ? -prod_q : prod_q;
      quo_s  = dz_q ? '1 : (neg_q ? -quo : quo);
      rem_s  = rneg_q ? -rem : rem;
      if (is_div_q) res = is_rem_q ? rem_s : quo_s;
      else          res = is_hi_q ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];
      fin = short_q | (is_div_q ? div_done : (cnt_q == n_q));
   end

   always_comb begin
      state_d  = state_q;
      short_d  = short_q;
      is_div_d = is_div_q;
      is_rem_d = is_rem_q;
      is_hi_d  = is_hi_q;
      word_d   = word_q;
      neg_d    = neg_q;
      rneg_d   = rneg_q;
      dz_d     = dz_q;
      cnt_d    = cnt_q;
      n_d      = n_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      prod_d   = prod_q;
      data_d   = data_q;
      if (bus.flush) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: if (bus.in_valid) begin
               state_d  = CALC;
               short_d  = ~req_ok | early_hit;
               is_div_d = req_div & ~short_d;
               is_rem_d = req_rem;
               is_hi_d  = req_hi & ~short_d;
               word_d   = bus.is_word;
               neg_d    = (a_neg ^ b_neg) & ~short_d;
               rneg_d   = a_neg;
               dz_d     = (b_ext == '0);
               cnt_d    = '0;
               n_d      = n_req;
               mcand_d  = a_mag;
               mplier_d = bus.is_word ? (b_mag << (XLEN - WLEN)) : b_mag;
               prod_d   = {{XLEN{1'b0}}, (early_hit && req_ok) ? early_res : {XLEN{1'b0}}};
            end
            CALC: if (fin) begin
               state_d = DONE;
               data_d  = ext_w(res, word_q, 1'b1);
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (!is_div_q) begin
                  // MSB-first shift-add; multiplier was pre-aligned to the top
                  prod_d   = {prod_q[2*XLEN-2:0], 1'b0} +
                             (mplier_q[XLEN-1] ? {{XLEN{1'b0}}, mcand_q} : {2*XLEN{1'b0}});
                  mplier_d = mplier_q << 1;
               end
            end
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         short_q  <= 1'b0;
         is_div_q <= 1'b0;
         is_rem_q <= 1'b0;
         is_hi_q  <= 1'b0;
         word_q   <= 1'b0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         dz_q     <= 1'b0;
         cnt_q    <= '0;
         n_q      <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         prod_q   <= '0;
         data_q   <= '0;
      end else begin
         state_q  <= state_d;
         short_q  <= short_d;
         is_div_q <= is_div_d;
         is_rem_q <= is_rem_d;
         is_hi_q  <= is_hi_d;
         word_q   <= word_d;
         neg_q    <= neg_d;
         rneg_q   <= rneg_d;
         dz_q     <= dz_d;
         cnt_q    <= cnt_d;
         n_q      <= n_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         prod_q   <= prod_d;
         data_q   <= data_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.data_rd   = data_q;

endmodule

// File: tb/tb_ysyx_22040125_mdu.sv
// Directed-vector bench for ysyx_22040125_mdu: results, latency, hold, flush and reset.
module tb_ysyx_22040125_mdu;
   import ysyx_22040125_mdu_pkg::*;

   localparam int unsigned XLEN = 64;
`ifdef MDU_EARLY_OUT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   int   n_total = 0;
   int   n_pass  = 0;

   ysyx_22040125_mdu_if #(.XLEN(XLEN)) bus ();

   ysyx_22040125_mdu #(
      .XLEN (XLEN),
      .WLEN (32)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, got, exp);
   endtask

   // special: divide-by-zero / overflow / zero-operand multiply (one-cycle when early-out built)
   task automatic run(input string tag, input logic [7:0] op, input logic word,
                      input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp,
                      input int n, input bit special, input int hold);
      int lat;
      int exp_lat;
      exp_lat = (EARLY && special) ? 1 : n + 1;
      @(negedge clk);
      check_eq({tag, "_idle_rdy"}, bus.in_ready, 1'b1);
      bus.in_valid = 1'b1;
      bus.op       = op;
      bus.is_word  = word;
      bus.src1     = a;
      bus.src2     = b;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      check_eq({tag, "_busy_rdy"}, {bus.busy, bus.in_ready}, 2'b10);
      lat = 0;
      while (!bus.out_valid && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check_eq({tag, "_lat"}, lat, exp_lat);
      check_eq({tag, "_data"}, bus.data_rd, exp);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         check_eq({tag, "_hold_data"}, bus.data_rd, exp);
         check_eq({tag, "_hold_vr"}, {bus.out_valid, bus.in_ready}, 2'b10);
      end
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      check_eq({tag, "_release"}, {bus.out_valid, bus.in_ready, bus.busy}, 3'b010);
   endtask

   initial begin
      int seen_valid;
      int seen_busy;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.op        = '0;
      bus.is_word   = 1'b0;
      bus.src1      = '0;
      bus.src2      = '0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b0;
      #1;
      check_eq("reset_ctl", {bus.in_ready, bus.out_valid, bus.busy}, 3'b100);
      check_eq("reset_data", bus.data_rd, 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      run("mul", 8'h01, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 64, 0, 10);
      run("mulhu", 8'h08, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 64, 0, 0);
      run("mulh", 8'h02, 1'b0, '1, '1, 64'd0, 64, 0, 0);
      run("mulhsu", 8'h04, 1'b0, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64, 0, 0);
      run("mulw", 8'h01, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 32, 0, 0);
      run("mul_zero", 8'h01, 1'b0, 64'd0, 64'd5, 64'd0, 64, 1, 0);
      run("divw_ovf", 8'h10, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000,
          32, 1, 0);
      run("remw_ovf", 8'h40, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0, 32, 1, 0);
      run("div_ovf", 8'h10, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000,
          64, 1, 0);
      run("rem_ovf", 8'h40, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 64, 1, 0);
      run("divu_dz", 8'h20, 1'b0, 64'h1234, 64'd0, '1, 64, 1, 0);
      run("remu_dz", 8'h80, 1'b0, 64'h1234, 64'd0, 64'h1234, 64, 1, 0);
      run("div_dz", 8'h10, 1'b0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, '1, 64, 1, 0);
      run("rem_dz", 8'h40, 1'b0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB,
          64, 1, 0);
      run("divu", 8'h20, 1'b0, 64'd100, 64'd7, 64'd14, 64, 0, 0);
      run("remu", 8'h80, 1'b0, 64'd100, 64'd7, 64'd2, 64, 0, 0);
      run("div_neg", 8'h10, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2,
          64, 0, 0);
      run("rem_neg", 8'h40, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE,
          64, 0, 0);
      run("divuw", 8'h20, 1'b1, 64'hDEAD_BEEF_FFFF_FFFF, 64'h10, 64'h0FFF_FFFF, 32, 0, 0);
      run("bad_op", 8'h03, 1'b0, 64'd9, 64'd9, 64'd0, 0, 0, 0);
      run("div_pos", 8'h10, 1'b0, 64'd1000, 64'd3, 64'd333, 64, 0, 0);

      // Flush in CALC cycle 20 together with a new request.
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.op       = 8'h01;
      bus.is_word  = 1'b0;
      bus.src1     = 64'd7;
      bus.src2     = 64'd9;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (19) @(posedge clk);
      @(negedge clk);
      bus.flush    = 1'b1;
      bus.in_valid = 1'b1;
      bus.op       = 8'h20;
      bus.src1     = 64'd100;
      bus.src2     = 64'd7;
      @(posedge clk);
      #1;
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      check_eq("flush_idle", {bus.busy, bus.out_valid, bus.in_ready}, 3'b001);
      seen_valid = 0;
      seen_busy  = 0;
      for (int i = 0; i < 80; i++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) seen_valid++;
         if (bus.busy) seen_busy++;
      end
      check_eq("flush_no_valid", seen_valid, 0);
      check_eq("flush_no_accept", seen_busy, 0);
      run("after_flush", 8'h20, 1'b0, 64'd100, 64'd7, 64'd14, 64, 0, 0);

      // Reset in the middle of a multiply.
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.op       = 8'h01;
      bus.src1     = 64'd3;
      bus.src2     = 64'd5;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_eq("midrst_ctl", {bus.in_ready, bus.busy, bus.out_valid}, 3'b100);
      check_eq("midrst_data", bus.data_rd, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      run("after_rst", 8'h01, 1'b0, 64'd3, 64'd5, 64'd15, 64, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
